// File: rtl/micro_bus_pkg.sv
// Shared definitions for peripherals on the Micro 8-bit processor bus.
//   ADDR_W / DATA_W : bus widths
//   OFF_*           : register offsets inside a peripheral's 4-byte window
//   CTRL_*          : bit positions inside the timer CTRL register
//   irq_state_e     : raise/acknowledge interrupt handshake states
package micro_bus_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] OFF_COUNT  = 2'd0;
    localparam logic [1:0] OFF_PERIOD = 2'd1;
    localparam logic [1:0] OFF_CLEAR  = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int unsigned CTRL_IRQ_EN = 0;
    localparam int unsigned CTRL_MISSED = 1;

    typedef enum logic [0:0] {
        IRQ_IDLE    = 1'b0,
        IRQ_PENDING = 1'b1
    } irq_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick strobe every PRESCALE cycles.
//   CLK   : clock
//   RESET : asynchronous active-low reset
//   clr   : synchronous restart of the divider (counter returns to 0)
//   tick  : high for the single cycle in which the counter wraps
module tick_prescaler #(
    parameter int unsigned PRESCALE = 10
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped millisecond timer on the Micro 8-bit bus with a periodic interrupt.
//   CLK                 : system clock
//   RESET               : asynchronous active-low reset
//   BUS_ADDR            : processor address bus
//   BUS_DATA            : shared tristate data bus, driven for one cycle after a read address
//   BUS_WE              : processor write enable
//   BUS_INTERRUPT_RAISE : interrupt request, held until acknowledged
//   BUS_INTERRUPT_ACK   : interrupt acknowledge
// Register window at BASE_ADDR: +0 tick count (R), +1 PERIOD (R/W), +2 clear (W, reads 0),
// +3 CTRL (R/W; bit0 IRQ_EN, bit1 MISSED sticky, write 1 to clear).
module bus_timer
    import micro_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'hF0,
    parameter int unsigned       CLK_FREQ_HZ    = 100000000,
    parameter int unsigned       TICK_HZ        = 1000,
    parameter logic [DATA_W-1:0] DEFAULT_PERIOD = 8'd100
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    inout  wire  [DATA_W-1:0] BUS_DATA,
    input  logic              BUS_WE,
    output logic              BUS_INTERRUPT_RAISE,
    input  logic              BUS_INTERRUPT_ACK
);

    localparam int unsigned PRESCALE = CLK_FREQ_HZ / TICK_HZ;

    if (PRESCALE < 2 || PRESCALE * TICK_HZ != CLK_FREQ_HZ) begin : g_bad_prescale
        $error("bus_timer: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
    end

    // Bus decode
    logic [ADDR_W-1:0] offset;
    logic              in_win, wr_en, rd_en;
    logic              wr_clear, wr_period, wr_ctrl;

    assign offset    = BUS_ADDR - BASE_ADDR;
    assign in_win    = (offset[ADDR_W-1:2] == '0);
    assign wr_en     = BUS_WE && in_win;
    assign rd_en     = !BUS_WE && in_win;
    assign wr_clear  = wr_en && (offset[1:0] == OFF_CLEAR);
    assign wr_period = wr_en && (offset[1:0] == OFF_PERIOD);
    assign wr_ctrl   = wr_en && (offset[1:0] == OFF_CTRL);

    // Tick generation
    logic tick;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .CLK  (CLK),
        .RESET(RESET),
        .clr  (wr_clear),
        .tick (tick)
    );

    // Counters
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] pcount_q, pcount_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic              fire_q, fire_d;

    always_comb begin
        count_d  = count_q;
        pcount_d = pcount_q;
        fire_d   = 1'b0;
        if (wr_clear) begin
            // Clear beats a coincident tick: everything reads 0 afterwards
            count_d  = '0;
            pcount_d = '0;
        end else begin
            if (tick) begin
                count_d = count_q + DATA_W'(1);
            end
            if (wr_period || period_q == '0) begin
                pcount_d = '0;
            end else if (tick) begin
                if (pcount_q == period_q - DATA_W'(1)) begin
                    pcount_d = '0;
                    fire_d   = 1'b1;
                end else begin
                    pcount_d = pcount_q + DATA_W'(1);
                end
            end
        end
    end

    assign period_d = wr_period ? BUS_DATA : period_q;

    // Control register and interrupt handshake
    logic       irq_en_q, irq_en_d;
    logic       missed_q, missed_d;
    logic       missed_set;
    irq_state_e state_q, state_d;

    always_comb begin
        state_d    = state_q;
        missed_set = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (fire_q && irq_en_q) begin
                    state_d = IRQ_PENDING;
                end
            end
            IRQ_PENDING: begin
                // ACK retires the old request even if a new fire lands the same cycle
                if (BUS_INTERRUPT_ACK) begin
                    state_d = IRQ_IDLE;
                end else if (fire_q) begin
                    missed_set = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        irq_en_d = irq_en_q;
        missed_d = missed_q;
        if (wr_ctrl) begin
            irq_en_d = BUS_DATA[CTRL_IRQ_EN];
            if (BUS_DATA[CTRL_MISSED]) begin
                missed_d = 1'b0;
            end
        end
        // A fresh overrun is never lost to a simultaneous clear
        if (missed_set) begin
            missed_d = 1'b1;
        end
    end

    assign BUS_INTERRUPT_RAISE = (state_q == IRQ_PENDING);

    // Registered read path
    logic [DATA_W-1:0] ctrl_rd;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_drive_q;

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
        ctrl_rd[CTRL_MISSED] = missed_q;
        case (offset[1:0])
            OFF_COUNT:  rd_data_d = count_q;
            OFF_PERIOD: rd_data_d = period_q;
            OFF_CTRL:   rd_data_d = ctrl_rd;
            default:    rd_data_d = '0;
        endcase
    end

    assign BUS_DATA = rd_drive_q ? rd_data_q : {DATA_W{1'bz}};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q    <= '0;
            pcount_q   <= '0;
            period_q   <= DEFAULT_PERIOD;
            fire_q     <= 1'b0;
            irq_en_q   <= 1'b1;
            missed_q   <= 1'b0;
            state_q    <= IRQ_IDLE;
            rd_data_q  <= '0;
            rd_drive_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            pcount_q   <= pcount_d;
            period_q   <= period_d;
            fire_q     <= fire_d;
            irq_en_q   <= irq_en_d;
            missed_q   <= missed_d;
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_drive_q <= rd_en;
        end
    end

endmodule
